// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: IF/ID record, fetch FSM states and the bubble encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

  function automatic if_id_t make_bubble(input logic [31:0] pc);
    if_id_t b;
    b.instr    = NOP_INSTR;
    b.pc       = pc;
    b.pc_plus4 = pc + 32'd4;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control bundle between the fetch FSM and the IF/ID pipeline register.
import riscv_pkg::*;

interface fetch_stage_if;
  logic        load;
  logic        flush;
  if_id_t      load_data;
  logic [31:0] flush_pc;
  if_id_t      q;

  modport master (output load, output flush, output load_data, output flush_pc, input q);
  modport slave  (input load, input flush, input load_data, input flush_pc, output q);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, load captures a fetched word, otherwise holds.
import riscv_pkg::*;

module if_id_reg (
  input logic           clk_i,
  input logic           rst_ni,
  fetch_stage_if.slave  ctrl
);

  if_id_t q_q;
  if_id_t q_d;

  // Flush has priority so a redirect or halt never lets a stale word through.
  always_comb begin
    q_d = q_q;
    if (ctrl.flush) begin
      q_d = make_bubble(ctrl.flush_pc);
    end else if (ctrl.load) begin
      q_d = ctrl.load_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= IF_ID_RESET;
    end else begin
      q_q <= q_d;
    end
  end

  assign ctrl.q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, boot/run/halt FSM and IF/ID capture.
import riscv_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 80
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic        if_id_valid_o,
  output logic        halted_o,
  output logic        misaligned_o
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_SIZE * 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misaligned_q, misaligned_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target_pc;

  fetch_stage_if ifc ();

  if_id_reg u_if_id_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ctrl   (ifc.slave)
  );

  assign pc_plus4  = pc_q + 32'd4;
  assign target_pc = {redirect_pc_i[31:2], 2'b00};

  // Next-state logic; redirect outranks the end-of-memory check, which outranks stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    misaligned_d  = redirect_i & (|redirect_pc_i[1:0]);
    ifc.load      = 1'b0;
    ifc.flush     = 1'b0;
    ifc.flush_pc  = pc_q;
    ifc.load_data = '{instr: instr_i, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};

    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        if (redirect_i) begin
          pc_d = target_pc;
        end
      end
      S_RUN: begin
        if (redirect_i) begin
          pc_d      = target_pc;
          ifc.flush = 1'b1;
        end else if (pc_q >= PC_LIMIT) begin
          ifc.flush = 1'b1;
          state_d   = S_HALT;
        end else if (!stall_i) begin
          ifc.load = 1'b1;
          pc_d     = pc_plus4;
        end
      end
      S_HALT: begin
        ifc.flush = 1'b1;
        if (redirect_i) begin
          pc_d    = target_pc;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_o             = pc_q;
  assign if_id_instr_o    = ifc.q.instr;
  assign if_id_pc_o       = ifc.q.pc;
  assign if_id_pc_plus4_o = ifc.q.pc_plus4;
  assign if_id_valid_o    = ifc.q.valid;
  assign halted_o         = (state_q == S_HALT);
  assign misaligned_o     = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, randomized run vs. reference model, corner sequences.
import riscv_pkg::*;

module tb_fetch_stage;

  localparam int MEM_SIZE = 80;

  logic        clk;
  logic        rstN;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] pcOut;
  logic [31:0] instrIn;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic [31:0] ifPcPlus4;
  logic        ifValid;
  logic        halted;
  logic        misaligned;

  logic [31:0] mem [MEM_SIZE];

  int checks = 0;
  int errors = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] mPc;
  logic        mBooting;
  logic        mHalted;
  logic        mMis;
  if_id_t      mIf;

  fetch_stage #(.RESET_PC(32'h0), .MEM_SIZE(MEM_SIZE)) dut (
    .clk_i            (clk),
    .rst_ni           (rstN),
    .stall_i          (stall),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirectPc),
    .pc_o             (pcOut),
    .instr_i          (instrIn),
    .if_id_instr_o    (ifInstr),
    .if_id_pc_o       (ifPc),
    .if_id_pc_plus4_o (ifPcPlus4),
    .if_id_valid_o    (ifValid),
    .halted_o         (halted),
    .misaligned_o     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr[31:2] < 30'(MEM_SIZE)) return mem[int'(addr[31:2])];
    return 32'h0;
  endfunction

  // Combinational instruction memory.
  always_comb instrIn = memWord(pcOut);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc      = 32'h0;
    mBooting = 1'b1;
    mHalted  = 1'b0;
    mMis     = 1'b0;
    mIf      = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
  endtask

  task automatic modelStep(input logic s, input logic r, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt  = rpc & 32'hFFFF_FFFC;
    mMis = r && (rpc % 4 != 0);
    if (mBooting) begin
      mBooting = 1'b0;
      if (r) mPc = tgt;
    end else if (mHalted) begin
      mIf = make_bubble(mPc);
      if (r) begin
        mPc     = tgt;
        mHalted = 1'b0;
      end
    end else if (r) begin
      mIf = make_bubble(mPc);
      mPc = tgt;
    end else if (mPc >= MEM_SIZE * 4) begin
      mIf     = make_bubble(mPc);
      mHalted = 1'b1;
    end else if (!s) begin
      mIf = '{instr: memWord(mPc), pc: mPc, pc_plus4: mPc + 32'd4, valid: 1'b1};
      mPc = mPc + 32'd4;
    end
  endtask

  task automatic checkModel();
    checkOutput("pc_o", pcOut, mPc);
    checkOutput("if_id_instr", ifInstr, mIf.instr);
    checkOutput("if_id_pc", ifPc, mIf.pc);
    checkOutput("if_id_pc_plus4", ifPcPlus4, mIf.pc_plus4);
    checkOutput("if_id_valid", 32'(ifValid), 32'(mIf.valid));
    checkOutput("halted", 32'(halted), 32'(mHalted));
    checkOutput("misaligned", 32'(misaligned), 32'(mMis));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check just after it.
  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall      = s;
    redirect   = r;
    redirectPc = rpc;
    @(posedge clk);
    modelStep(s, r, rpc);
    #1;
    checkModel();
  endtask

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] ePc;
    logic        eValid;
    logic [31:0] eInstr;
    logic [31:0] eIfPc;
    logic        eMis;
    logic        eHalt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = $urandom;
    mem[0]  = 32'h0051_8193;
    mem[1]  = 32'h00a2_0213;
    mem[40] = 32'h00ae_0e13;

    vecs[0] = '{1'b0, 1'b0, 32'h0,  32'h0,  1'b0, NOP_INSTR,    32'h0,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  32'h4,  1'b1, 32'h00518193, 32'h0,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h0,  32'h8,  1'b1, 32'h00a20213, 32'h4,  1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0,  32'h8,  1'b1, 32'h00a20213, 32'h4,  1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0,  32'h8,  1'b1, 32'h00a20213, 32'h4,  1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0,  32'h8,  1'b1, 32'h00a20213, 32'h4,  1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'hA0, 32'hA0, 1'b0, NOP_INSTR,    32'h8,  1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0,  32'hA4, 1'b1, 32'h00ae0e13, 32'hA0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 32'h8A, 32'h88, 1'b0, NOP_INSTR,    32'hA4, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 32'h0,  32'h8C, 1'b1, mem[34],      32'h88, 1'b0, 1'b0};

    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPc = 32'h0;
    rstN       = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset pc_o", pcOut, 32'h0);
    checkOutput("reset instr", ifInstr, NOP_INSTR);
    checkOutput("reset valid", 32'(ifValid), 32'h0);
    checkOutput("reset halted", 32'(halted), 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      checkOutput($sformatf("vec%0d pc_o", i), pcOut, vecs[i].ePc);
      checkOutput($sformatf("vec%0d valid", i), 32'(ifValid), 32'(vecs[i].eValid));
      checkOutput($sformatf("vec%0d instr", i), ifInstr, vecs[i].eInstr);
      checkOutput($sformatf("vec%0d if_pc", i), ifPc, vecs[i].eIfPc);
      checkOutput($sformatf("vec%0d misaligned", i), 32'(misaligned), 32'(vecs[i].eMis));
      checkOutput($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].eHalt));
    end

    $display("[TB] randomized run against reference model");
    for (int i = 0; i < 400; i++) begin
      logic        s;
      logic        r;
      logic [31:0] rpc;
      s   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 15) == 0);
      rpc = 32'($urandom_range(0, MEM_SIZE * 4 + 16));
      if ($urandom_range(0, 31) == 0) rpc = 32'hFFFF_FFFE;
      applyStimulus(s, r, rpc);
    end

    $display("[TB] run to end of memory and halt");
    applyStimulus(1'b0, 1'b1, 32'h138);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("end if_pc", ifPc, 32'h13C);
    checkOutput("end instr", ifInstr, mem[79]);
    checkOutput("end pc_o", pcOut, 32'h140);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("halt valid", 32'(ifValid), 32'h0);
    checkOutput("halt halted", 32'(halted), 32'h1);
    checkOutput("halt pc_o", pcOut, 32'h140);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("halt hold pc_o", pcOut, 32'h140);
    checkOutput("halt hold halted", 32'(halted), 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("unhalt halted", 32'(halted), 32'h0);
    checkOutput("unhalt pc_o", pcOut, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("refetch instr", ifInstr, 32'h00518193);
    checkOutput("refetch valid", 32'(ifValid), 32'h1);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1'b0, 1'b0, 32'h0);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput("async pc_o", pcOut, 32'h0);
    checkOutput("async instr", ifInstr, NOP_INSTR);
    checkOutput("async if_pc", ifPc, 32'h0);
    checkOutput("async pc_plus4", ifPcPlus4, 32'h0);
    checkOutput("async valid", 32'(ifValid), 32'h0);
    checkOutput("async halted", 32'(halted), 32'h0);
    checkOutput("async misaligned", 32'(misaligned), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("post-reset instr", ifInstr, 32'h00518193);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
